// File: rtl/mul_float_pkg.sv
// -----------------------------------------------------------------------------
// mul_float_pkg
// Shared types and constants for the floating-point multiplier arbiter slice.
//   MUL_FLOAT_LATENCY  : default multiplier pipeline depth
//   mul_float_id_t     : requester id (0 or 1)
//   mul_float_result_t : packed multiplier result {sign, exp, fract, except}
//   mul_float_tag_t    : one tag-pipeline entry {valid, id}
// -----------------------------------------------------------------------------
package mul_float_pkg;

   localparam int MUL_FLOAT_LATENCY = 2;

   typedef logic mul_float_id_t;

   typedef struct packed {
      logic        sign;
      logic [9:0]  exp;
      logic [47:0] fract;
      logic [5:0]  except;
   } mul_float_result_t;

   typedef struct packed {
      logic          valid;
      mul_float_id_t id;
   } mul_float_tag_t;

endpackage

// File: rtl/mul_float_tag_pipe.sv
// -----------------------------------------------------------------------------
// mul_float_tag_pipe
// P_LATENCY-deep shift register of {valid, id} tags that tracks which requester
// owns each operation inside the multiplier. It advances on the same enable as
// the multiplier's pipeline registers, so the head entry always describes the
// result currently presented by the multiplier.
// Ports:
//   iCLOCK     : clock, rising edge
//   inRESET    : asynchronous active-low reset
//   clear      : synchronous clear, wins over enable
//   enable     : shift enable
//   push_valid : valid bit inserted at the tail
//   push_id    : requester id inserted at the tail
//   head_valid : valid bit of the oldest entry
//   head_id    : requester id of the oldest entry
// -----------------------------------------------------------------------------
module mul_float_tag_pipe
   import mul_float_pkg::*;
#(
   parameter int P_LATENCY = MUL_FLOAT_LATENCY
) (
   input  logic          iCLOCK,
   input  logic          inRESET,
   input  logic          clear,
   input  logic          enable,
   input  logic          push_valid,
   input  mul_float_id_t push_id,
   output logic          head_valid,
   output mul_float_id_t head_id
);

   mul_float_tag_t entry [P_LATENCY];

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         for (int i = 0; i < P_LATENCY; i++) begin
            entry[i] <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < P_LATENCY; i++) begin
            entry[i] <= '0;
         end
      end else if (enable) begin
         entry[0] <= {push_valid, push_id};
         for (int i = 1; i < P_LATENCY; i++) begin
            entry[i] <= entry[i-1];
         end
      end
   end

   assign head_valid = entry[P_LATENCY-1].valid;
   assign head_id    = entry[P_LATENCY-1].id;

endmodule

// File: rtl/mul_float_arb.sv
// -----------------------------------------------------------------------------
// mul_float_arb
// Two-requester arbiter in front of a shared pipelined floating-point
// multiplier. Grants at most one requester per cycle, tags each accepted
// operation with its requester id, and routes returning results back to the
// owner. A busy consumer stalls the entire pipe (head-of-line blocking).
// Configuration macro:
//   MUL_FLOAT_ARB_RR_EN : defined -> round-robin contention policy with a 1-bit
//                         pointer; undefined -> requester 0 always wins.
// Ports:
//   iCLOCK, inRESET, iRESET_SYNC : clock, async active-low reset, sync clear
//   iREQ0/1, oBUSY0/1            : requester handshakes
//   iDATA0_A/B, iDATA1_A/B       : requester operands
//   oVALID0/1, iBUSY0/1          : result handshakes per requester
//   oRESULT                      : shared result bus (pass-through)
//   oMUL_REQ, iMUL_BUSY          : multiplier input handshake
//   oMUL_DATA_A/B                : multiplier operands
//   iMUL_VALID, oMUL_BUSY        : multiplier output handshake
//   iMUL_RESULT                  : multiplier result
//   oERR                         : sticky protocol error
// -----------------------------------------------------------------------------
module mul_float_arb
   import mul_float_pkg::*;
#(
   parameter int P_LATENCY = MUL_FLOAT_LATENCY
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iRESET_SYNC,
   input  logic        iREQ0,
   input  logic        iREQ1,
   output logic        oBUSY0,
   output logic        oBUSY1,
   input  logic [31:0] iDATA0_A,
   input  logic [31:0] iDATA0_B,
   input  logic [31:0] iDATA1_A,
   input  logic [31:0] iDATA1_B,
   output logic        oVALID0,
   output logic        oVALID1,
   input  logic        iBUSY0,
   input  logic        iBUSY1,
   output logic [64:0] oRESULT,
   output logic        oMUL_REQ,
   input  logic        iMUL_BUSY,
   output logic [31:0] oMUL_DATA_A,
   output logic [31:0] oMUL_DATA_B,
   input  logic        iMUL_VALID,
   output logic        oMUL_BUSY,
   input  logic [64:0] iMUL_RESULT,
   output logic        oERR
);

   localparam int MASK_W = $clog2(P_LATENCY + 1);

   logic          run;
   logic          stall;
   logic          grant0;
   logic          grant1;
   mul_float_id_t grant_id;
   logic          head_valid;
   mul_float_id_t head_id;
   logic          err;
   logic [MASK_W-1:0] mask_cnt;

`ifdef MUL_FLOAT_ARB_RR_EN
   mul_float_id_t rr_ptr;
`endif

   // Nothing is granted or delivered while either reset is asserted.
   assign run      = inRESET && !iRESET_SYNC;

   assign oMUL_BUSY = iMUL_VALID && (head_id ? iBUSY1 : iBUSY0);
   assign stall     = oMUL_BUSY || iMUL_BUSY;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (run && !stall) begin
         if (iREQ0 && iREQ1) begin
`ifdef MUL_FLOAT_ARB_RR_EN
            grant0 = !rr_ptr;
            grant1 = rr_ptr;
`else
            grant0 = 1'b1;
`endif
         end else begin
            grant0 = iREQ0;
            grant1 = iREQ1;
         end
      end
   end

   assign grant_id    = grant1;
   assign oBUSY0      = stall || !grant0;
   assign oBUSY1      = stall || !grant1;
   assign oMUL_REQ    = grant0 || grant1;
   assign oMUL_DATA_A = grant1 ? iDATA1_A : iDATA0_A;
   assign oMUL_DATA_B = grant1 ? iDATA1_B : iDATA0_B;

   mul_float_tag_pipe #(
      .P_LATENCY (P_LATENCY)
   ) u_tag_pipe (
      .iCLOCK     (iCLOCK),
      .inRESET    (inRESET),
      .clear      (iRESET_SYNC),
      .enable     (!stall),
      .push_valid (oMUL_REQ),
      .push_id    (grant_id),
      .head_valid (head_valid),
      .head_id    (head_id)
   );

   assign oVALID0 = run && iMUL_VALID && head_valid && (head_id == 1'b0);
   assign oVALID1 = run && iMUL_VALID && head_valid && (head_id == 1'b1);
   assign oRESULT = iMUL_RESULT;

`ifdef MUL_FLOAT_ARB_RR_EN
   // Pointer moves to the other requester after every accepted grant.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         rr_ptr <= 1'b0;
      end else if (iRESET_SYNC) begin
         rr_ptr <= 1'b0;
      end else if (oMUL_REQ) begin
         rr_ptr <= ~grant_id;
      end
   end
`endif

   // After a sync clear the multiplier may still emit results whose tags were
   // discarded; the mask hides those from the error check. It counts pipeline
   // advances, since stray results can only drain while the pipe moves.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         mask_cnt <= '0;
      end else if (iRESET_SYNC) begin
         mask_cnt <= MASK_W'(P_LATENCY);
      end else if (!stall && (mask_cnt != '0)) begin
         mask_cnt <= mask_cnt - MASK_W'(1);
      end
   end

   // Multiplier output valid must track the head tag whenever the pipe moves.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         err <= 1'b0;
      end else if (iRESET_SYNC) begin
         err <= 1'b0;
      end else if (!stall && (mask_cnt == '0) && (iMUL_VALID != head_valid)) begin
         err <= 1'b1;
      end
   end

   assign oERR = err;

endmodule

// File: tb/tb_mul_float_arb.sv
// -----------------------------------------------------------------------------
// tb_mul_float_arb
// Directed testbench for mul_float_arb with a 2-stage behavioural multiplier
// stub. Each scenario task drives stimulus and checks outputs inline.
// -----------------------------------------------------------------------------
module tb_mul_float_arb;

   logic        iCLOCK = 1'b0;
   logic        inRESET = 1'b0;
   logic        iRESET_SYNC = 1'b0;
   logic        iREQ0 = 1'b0;
   logic        iREQ1 = 1'b0;
   logic        oBUSY0, oBUSY1;
   logic [31:0] iDATA0_A = '0, iDATA0_B = '0, iDATA1_A = '0, iDATA1_B = '0;
   logic        oVALID0, oVALID1;
   logic        iBUSY0 = 1'b0, iBUSY1 = 1'b0;
   logic [64:0] oRESULT;
   logic        oMUL_REQ;
   logic        iMUL_BUSY = 1'b0;
   logic [31:0] oMUL_DATA_A, oMUL_DATA_B;
   logic        iMUL_VALID;
   logic        oMUL_BUSY;
   logic [64:0] iMUL_RESULT;
   logic        oERR;

   logic        force_valid = 1'b0;
   int          errors = 0;
   int          checks = 0;

   // 1.0*3.0 and 2.0*4.0 as {sign, exp, fract, except}
   localparam logic [64:0] RES_1X3 = {1'b0, 10'd128, 48'h6000_0000_0000, 6'd0};
   localparam logic [64:0] RES_2X4 = {1'b0, 10'd130, 48'h4000_0000_0000, 6'd0};
   localparam logic [64:0] RES_1X2 = {1'b0, 10'd128, 48'h4000_0000_0000, 6'd0};

   always #5 iCLOCK = ~iCLOCK;

   mul_float_arb #(.P_LATENCY(2)) dut (
      .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
      .iREQ0(iREQ0), .iREQ1(iREQ1), .oBUSY0(oBUSY0), .oBUSY1(oBUSY1),
      .iDATA0_A(iDATA0_A), .iDATA0_B(iDATA0_B),
      .iDATA1_A(iDATA1_A), .iDATA1_B(iDATA1_B),
      .oVALID0(oVALID0), .oVALID1(oVALID1),
      .iBUSY0(iBUSY0), .iBUSY1(iBUSY1), .oRESULT(oRESULT),
      .oMUL_REQ(oMUL_REQ), .iMUL_BUSY(iMUL_BUSY),
      .oMUL_DATA_A(oMUL_DATA_A), .oMUL_DATA_B(oMUL_DATA_B),
      .iMUL_VALID(iMUL_VALID), .oMUL_BUSY(oMUL_BUSY),
      .iMUL_RESULT(iMUL_RESULT), .oERR(oERR)
   );

   // Behavioural multiplier: normal-number product, no rounding.
   function automatic logic [64:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic [9:0]  e;
      logic [47:0] f;
      e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
      f = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      return {a[31] ^ b[31], e, f, 6'd0};
   endfunction

   logic        mv0, mv1;
   logic [64:0] md0, md1;

   always @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         mv0 <= 1'b0;
         mv1 <= 1'b0;
         md0 <= '0;
         md1 <= '0;
      end else if (!(oMUL_BUSY || iMUL_BUSY)) begin
         mv0 <= oMUL_REQ;
         md0 <= fmul(oMUL_DATA_A, oMUL_DATA_B);
         mv1 <= mv0;
         md1 <= md0;
      end
   end

   assign iMUL_VALID  = mv1 || force_valid;
   assign iMUL_RESULT = md1;

   task automatic test_reset();
      @(negedge iCLOCK);
      iREQ0 = 1'b1;
      #1;
      checks++; if (oVALID0 !== 1'b0 || oVALID1 !== 1'b0) begin errors++;
         $display("[TB] FAIL reset_valid: got %b%b expected 00", oVALID0, oVALID1); end
      checks++; if (oMUL_REQ !== 1'b0) begin errors++;
         $display("[TB] FAIL reset_mul_req: got %b expected 0", oMUL_REQ); end
      checks++; if (oBUSY0 !== 1'b1) begin errors++;
         $display("[TB] FAIL reset_busy0: got %b expected 1", oBUSY0); end
      checks++; if (oERR !== 1'b0) begin errors++;
         $display("[TB] FAIL reset_err: got %b expected 0", oERR); end
      iREQ0 = 1'b0;
      @(negedge iCLOCK);
      inRESET = 1'b1;
      @(negedge iCLOCK);
   endtask

   task automatic test_single();
      @(negedge iCLOCK);
      iREQ0 = 1'b1; iDATA0_A = 32'h3F80_0000; iDATA0_B = 32'h4000_0000;
      #1;
      checks++; if (oBUSY0 !== 1'b0 || oMUL_REQ !== 1'b1) begin errors++;
         $display("[TB] FAIL single_grant: got busy0=%b req=%b expected 0 1", oBUSY0, oMUL_REQ); end
      checks++; if (oMUL_DATA_A !== 32'h3F80_0000 || oMUL_DATA_B !== 32'h4000_0000) begin errors++;
         $display("[TB] FAIL single_data: got %h %h expected 3f800000 40000000", oMUL_DATA_A, oMUL_DATA_B); end
      @(negedge iCLOCK);
      iREQ0 = 1'b0;
      #1;
      checks++; if (oVALID0 !== 1'b0) begin errors++;
         $display("[TB] FAIL single_early: got %b expected 0", oVALID0); end
      @(negedge iCLOCK);
      #1;
      checks++; if (oVALID0 !== 1'b1 || oVALID1 !== 1'b0) begin errors++;
         $display("[TB] FAIL single_valid: got v0=%b v1=%b expected 1 0", oVALID0, oVALID1); end
      checks++; if (oRESULT !== RES_1X2) begin errors++;
         $display("[TB] FAIL single_result: got %h expected %h", oRESULT, RES_1X2); end
      @(negedge iCLOCK);
      #1;
      checks++; if (oVALID0 !== 1'b0 || oVALID1 !== 1'b0) begin errors++;
         $display("[TB] FAIL single_after: got v0=%b v1=%b expected 0 0", oVALID0, oVALID1); end
   endtask

   task automatic test_contention();
      logic exp_gnt [4];
`ifdef MUL_FLOAT_ARB_RR_EN
      exp_gnt = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_gnt = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      @(negedge iCLOCK);
      iRESET_SYNC = 1'b1;
      @(negedge iCLOCK);
      iRESET_SYNC = 1'b0;
      iDATA0_A = 32'h3F80_0000; iDATA0_B = 32'h4040_0000;
      iDATA1_A = 32'h4000_0000; iDATA1_B = 32'h4080_0000;
      for (int k = 0; k < 7; k++) begin
         if (k > 0) @(negedge iCLOCK);
         iREQ0 = (k < 4); iREQ1 = (k < 4);
         #1;
         if (k < 4) begin
            checks++; if (oBUSY0 !== exp_gnt[k] || oBUSY1 !== !exp_gnt[k]) begin errors++;
               $display("[TB] FAIL contention_grant%0d: got busy0=%b busy1=%b expected %b %b",
                        k, oBUSY0, oBUSY1, exp_gnt[k], !exp_gnt[k]); end
            checks++; if (oMUL_DATA_A !== (exp_gnt[k] ? 32'h4000_0000 : 32'h3F80_0000)) begin errors++;
               $display("[TB] FAIL contention_data%0d: got %h", k, oMUL_DATA_A); end
         end
         if (k >= 2 && k < 6) begin
            checks++; if (oVALID0 !== !exp_gnt[k-2] || oVALID1 !== exp_gnt[k-2]) begin errors++;
               $display("[TB] FAIL contention_order%0d: got v0=%b v1=%b expected %b %b",
                        k, oVALID0, oVALID1, !exp_gnt[k-2], exp_gnt[k-2]); end
            checks++; if (oRESULT !== (exp_gnt[k-2] ? RES_2X4 : RES_1X3)) begin errors++;
               $display("[TB] FAIL contention_result%0d: got %h", k, oRESULT); end
         end
         if (k == 6) begin
            checks++; if (oVALID0 !== 1'b0 || oVALID1 !== 1'b0) begin errors++;
               $display("[TB] FAIL contention_drain: got v0=%b v1=%b expected 0 0", oVALID0, oVALID1); end
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge iCLOCK);
      iREQ0 = 1'b1; iREQ1 = 1'b0;
      @(negedge iCLOCK);
      @(negedge iCLOCK);
      iREQ0 = 1'b0; iRESET_SYNC = 1'b1;
      #1;
      checks++; if (oVALID0 !== 1'b0 || oMUL_REQ !== 1'b0) begin errors++;
         $display("[TB] FAIL midreset_cycle0: got v0=%b req=%b expected 0 0", oVALID0, oMUL_REQ); end
      @(negedge iCLOCK);
      iRESET_SYNC = 1'b0; iREQ0 = 1'b1; iREQ1 = 1'b1;
      #1;
      checks++; if (oVALID0 !== 1'b0 || oVALID1 !== 1'b0) begin errors++;
         $display("[TB] FAIL midreset_stray: got v0=%b v1=%b expected 0 0", oVALID0, oVALID1); end
      checks++; if (oBUSY0 !== 1'b0 || oBUSY1 !== 1'b1) begin errors++;
         $display("[TB] FAIL midreset_ptr: got busy0=%b busy1=%b expected 0 1", oBUSY0, oBUSY1); end
      @(negedge iCLOCK);
      iREQ0 = 1'b0; iREQ1 = 1'b0;
      #1;
      checks++; if (oVALID0 !== 1'b0 || oVALID1 !== 1'b0 || oERR !== 1'b0) begin errors++;
         $display("[TB] FAIL midreset_quiet: got v0=%b v1=%b err=%b expected 0 0 0", oVALID0, oVALID1, oERR); end
      @(negedge iCLOCK);
      #1;
      checks++; if (oVALID0 !== 1'b1 || oERR !== 1'b0) begin errors++;
         $display("[TB] FAIL midreset_resume: got v0=%b err=%b expected 1 0", oVALID0, oERR); end
      checks++; if (oRESULT !== RES_1X3) begin errors++;
         $display("[TB] FAIL midreset_result: got %h expected %h", oRESULT, RES_1X3); end
      @(negedge iCLOCK);
   endtask

   task automatic test_stall();
      @(negedge iCLOCK);
      iMUL_BUSY = 1'b1; iREQ0 = 1'b1;
      #1;
      checks++; if (oBUSY0 !== 1'b1 || oMUL_REQ !== 1'b0) begin errors++;
         $display("[TB] FAIL mulbusy_block: got busy0=%b req=%b expected 1 0", oBUSY0, oMUL_REQ); end
      @(negedge iCLOCK);
      iMUL_BUSY = 1'b0; iREQ0 = 1'b0; iREQ1 = 1'b1;
      #1;
      checks++; if (oBUSY1 !== 1'b0) begin errors++;
         $display("[TB] FAIL stall_accept1: got %b expected 0", oBUSY1); end
      @(negedge iCLOCK);
      iREQ1 = 1'b0; iREQ0 = 1'b1;
      #1;
      checks++; if (oBUSY0 !== 1'b0) begin errors++;
         $display("[TB] FAIL stall_accept0: got %b expected 0", oBUSY0); end
      for (int k = 0; k < 3; k++) begin
         @(negedge iCLOCK);
         iBUSY1 = 1'b1;
         #1;
         checks++; if (oVALID1 !== 1'b1 || oMUL_BUSY !== 1'b1) begin errors++;
            $display("[TB] FAIL stall_hold%0d: got v1=%b mulbusy=%b expected 1 1", k, oVALID1, oMUL_BUSY); end
         checks++; if (oBUSY0 !== 1'b1 || oBUSY1 !== 1'b1 || oMUL_REQ !== 1'b0) begin errors++;
            $display("[TB] FAIL stall_block%0d: got busy0=%b busy1=%b req=%b expected 1 1 0",
                     k, oBUSY0, oBUSY1, oMUL_REQ); end
      end
      @(negedge iCLOCK);
      iBUSY1 = 1'b0; iREQ0 = 1'b0;
      #1;
      checks++; if (oVALID1 !== 1'b1 || oMUL_BUSY !== 1'b0 || oRESULT !== RES_2X4) begin errors++;
         $display("[TB] FAIL stall_release1: got v1=%b mulbusy=%b res=%h", oVALID1, oMUL_BUSY, oRESULT); end
      @(negedge iCLOCK);
      #1;
      checks++; if (oVALID0 !== 1'b1 || oVALID1 !== 1'b0 || oRESULT !== RES_1X3) begin errors++;
         $display("[TB] FAIL stall_release0: got v0=%b v1=%b res=%h", oVALID0, oVALID1, oRESULT); end
      @(negedge iCLOCK);
      #1;
      checks++; if (oVALID0 !== 1'b0 || oVALID1 !== 1'b0 || oERR !== 1'b0) begin errors++;
         $display("[TB] FAIL stall_drain: got v0=%b v1=%b err=%b expected 0 0 0", oVALID0, oVALID1, oERR); end
   endtask

   task automatic test_protocol_err();
      @(negedge iCLOCK);
      force_valid = 1'b1;
      #1;
      checks++; if (oVALID0 !== 1'b0 || oERR !== 1'b0) begin errors++;
         $display("[TB] FAIL perr_before: got v0=%b err=%b expected 0 0", oVALID0, oERR); end
      @(negedge iCLOCK);
      force_valid = 1'b0;
      #1;
      checks++; if (oERR !== 1'b1) begin errors++;
         $display("[TB] FAIL perr_set: got %b expected 1", oERR); end
      repeat (3) @(negedge iCLOCK);
      #1;
      checks++; if (oERR !== 1'b1) begin errors++;
         $display("[TB] FAIL perr_sticky: got %b expected 1", oERR); end
      inRESET = 1'b0;
      #1;
      checks++; if (oERR !== 1'b0) begin errors++;
         $display("[TB] FAIL perr_clear: got %b expected 0", oERR); end
      @(negedge iCLOCK);
      inRESET = 1'b1;
      @(negedge iCLOCK);
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_reset_mid();
      test_stall();
      test_protocol_err();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul_float_arb.md
MUL_FLOAT_ARB -- requirements
Module: mul_float_arb

Interface
REQ-001 Parameter P_LATENCY, default 2: multiplier pipeline depth, and so the depth of the arbiter's tag pipeline.
REQ-002 iCLOCK  in  1  clock; all state updates on rising edge.
REQ-003 inRESET  in  1  reset, asynchronous, active-low.
REQ-004 iRESET_SYNC  in  1  synchronous clear, active-high.
REQ-005 iREQ0 / iREQ1  in  1  requester 0/1 operation request.
REQ-006 oBUSY0 / oBUSY1  out  1  requester 0/1 request not accepted this cycle.
REQ-007 iDATA0_A, iDATA0_B, iDATA1_A, iDATA1_B  in  32  IEEE-754 single operands per requester.
REQ-008 oVALID0 / oVALID1  out  1  result valid for requester 0/1.
REQ-009 iBUSY0 / iBUSY1  in  1  requester 0/1 result consumer busy.
REQ-010 oRESULT  out  65  shared result bus: {sign, exp[9:0], fract[47:0], except[5:0]}.
REQ-011 oMUL_REQ  out  1  request to the multiplier.
REQ-012 iMUL_BUSY  in  1  multiplier input busy.
REQ-013 oMUL_DATA_A, oMUL_DATA_B  out  32  operands to the multiplier.
REQ-014 iMUL_VALID  in  1  multiplier result valid.
REQ-015 oMUL_BUSY  out  1  result-side stall to the multiplier.
REQ-016 iMUL_RESULT  in  65  multiplier result, same packing as oRESULT.
REQ-017 oERR  out  1  sticky protocol error.

Function
REQ-018 Stall condition: stall = oMUL_BUSY || iMUL_BUSY.
REQ-019 oMUL_BUSY = iMUL_VALID && (head tag id ? iBUSY1 : iBUSY0), driven combinationally.
REQ-020 Grant is issued only when stall = 0, and to at most one requester per cycle.
REQ-021 A lone requester is granted whenever stall = 0.
REQ-022 Contention (both iREQ high) is resolved per REQ-040/REQ-041.
REQ-023 oBUSYx = stall || !grantx, driven combinationally; a request is accepted when iREQx && !oBUSYx.
REQ-024 oMUL_REQ = grant0 || grant1.
REQ-025 oMUL_DATA_A/B are muxed combinationally from the granted requester, and driven from requester 0 when there is no grant.
REQ-026 The tag pipeline has P_LATENCY entries of {valid, id}.
REQ-027 When stall = 0, the tag pipeline shifts once per cycle, inserting {oMUL_REQ, granted id}; when stall = 1, it holds.
REQ-028 Because the tag pipeline advances on the multiplier's register enable, latency equals P_LATENCY cycles from acceptance to oVALIDx when unstalled.
REQ-029 oVALIDx = iMUL_VALID && head.valid && head.id == x; oRESULT = iMUL_RESULT, passed through.
REQ-030 Results return in acceptance order, and no result is dropped or duplicated under any stall pattern.
REQ-031 A busy consumer stalls the whole pipe, including the other requester (head-of-line blocking is accepted by design).
REQ-032 oERR is set when iMUL_VALID != head.valid in a cycle with stall = 0, and stays set until reset.
REQ-033 A request held with oBUSYx = 1 keeps its operands stable; the arbiter does not register the operands.

Reset
REQ-034 inRESET low asynchronously clears all tag entries, the RR pointer (to 0) and oERR.
REQ-035 iRESET_SYNC clears the same state on the next edge, with priority over all other updates.
REQ-036 While in reset: oVALID0/1 = 0, oMUL_REQ = 0, oERR = 0.
REQ-037 A reset in mid-operation discards in-flight tags; results then arriving with cleared tags raise no oVALID, and oERR is masked for P_LATENCY cycles after iRESET_SYNC.

Configuration
REQ-038 Macro MUL_FLOAT_ARB_RR_EN selects the contention policy.
REQ-039 Round-robin pointer behaviour with MUL_FLOAT_ARB_RR_EN defined: a 1-bit pointer, updated on every accepted grant to the non-granted id.
REQ-040 With MUL_FLOAT_ARB_RR_EN defined: contention grants the requester indicated by the RR pointer.
REQ-041 Without MUL_FLOAT_ARB_RR_EN: fixed priority, requester 0 always wins contention, and no pointer register exists.

Structure
REQ-042 Package mul_float_pkg holds: the result struct typedef (sign, exp 10b, fract 48b, except 6b), the requester-id typedef, and constant MUL_FLOAT_LATENCY = 2.
REQ-043 Sub-module mul_float_tag_pipe implements the P_LATENCY-deep {valid, id} shift register with enable and synchronous clear.

Verification
REQ-044 Single request: iREQ0 with A = 0x3F800000, B = 0x40000000 -> oVALID0 two cycles later; sign 0, exp 10'd128, fract 48'h4000_0000_0000; oVALID1 stays 0.
REQ-045 Contention: both requesters held high for 4 cycles -> with the macro defined, grants go 0,1,0,1 and results return in that order; without the macro, grants go 0,0,0,0.
REQ-046 Consumer stall: iBUSY1 high while a requester-1 result is at the head -> oMUL_BUSY = 1 and oBUSY0 = oBUSY1 = 1, with the pipe frozen; on release, the results are delivered in order and none is lost.
REQ-047 Reset mid-flight: iRESET_SYNC pulsed with 2 results in flight -> no oVALID0/1 for the next 2 cycles, RR pointer = 0, oERR = 0.
REQ-048 Protocol error: iMUL_VALID forced high with an empty head tag -> oERR = 1 and stays 1 until inRESET is low.
